// File: rtl/pulse_gen_v4.sv
// ---------------------------------------------------------------------------
// pulse_gen_v4 -- multi-channel, mode-selectable gate pulse generator.
//
// Each of NUM_CH channels turns a trigger into a gate pulse of L cycles,
// where L is derived from pulse_len at the moment the trigger is accepted.
// The pulse rises combinationally in the trigger cycle (zero latency) and
// is then held by a per-channel counter for the remaining L-1 cycles.
//
// Modes (latched per channel at accept):
//   00 one-shot  : done is sticky and blocks new triggers until rearm/reset
//   01 re-arm    : triggers during a pulse are ignored, done is a strobe
//   10 retrigger : a trigger during a pulse restarts it, done is a strobe
//   11           : same as 01
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   en         per-channel trigger (level, or rising edge with macro below)
//   mode       pulse mode, see above
//   pulse_len  requested length, shared by all channels (0 -> 1, clamped
//              to MAX_CYCLES)
//   rearm      per-channel clear of the sticky one-shot done flag
//   out_pulse  gate pulse, high for exactly L cycles per accepted trigger
//   busy       registered: channel is counting after its trigger cycle
//   done       registered completion (sticky in one-shot, strobe otherwise)
//
// Optional feature: define PULSE_GEN_EDGE_TRIG_EN to trigger on the rising
// edge of en instead of its level (one pulse per edge in every mode).
//
// Handshake note: there is no valid/ready pair here; en is sampled every
// cycle and "accept" is the per-channel condition under which it starts a
// pulse. A trigger that is not accepted is simply dropped.
// ---------------------------------------------------------------------------
module pulse_gen_v4 #(
    parameter  int NUM_CH     = 4,
    parameter  int MAX_CYCLES = 256,
    localparam int LEN_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] en,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  pulse_len,
    input  logic [NUM_CH-1:0] rearm,
    output logic [NUM_CH-1:0] out_pulse,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    typedef enum logic [1:0] {
        MODE_ONE_SHOT = 2'b00,
        MODE_REARM    = 2'b01,
        MODE_RETRIG   = 2'b10
    } mode_e;

    // Per-channel state
    logic [LEN_W-1:0]  cnt_q   [NUM_CH];
    logic [LEN_W-1:0]  len_q   [NUM_CH];
    mode_e             mode_q  [NUM_CH];
    logic [NUM_CH-1:0] counting_q;
    logic [NUM_CH-1:0] done_q;

    // Next-state
    logic [LEN_W-1:0]  cnt_d   [NUM_CH];
    logic [LEN_W-1:0]  len_d   [NUM_CH];
    mode_e             mode_d  [NUM_CH];
    logic [NUM_CH-1:0] counting_d;
    logic [NUM_CH-1:0] done_d;

    logic [NUM_CH-1:0] trig;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] restart;
    logic [LEN_W-1:0]  len_eff;
    mode_e             mode_in;

`ifdef PULSE_GEN_EDGE_TRIG_EN
    logic [NUM_CH-1:0] en_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_d <= '0;
        end else begin
            en_d <= en;
        end
    end

    assign trig = en & ~en_d;
`else
    assign trig = en;
`endif

    // Effective length: 0 is promoted to 1, oversize requests are clamped.
    always_comb begin
        len_eff = pulse_len;
        if (pulse_len == '0) begin
            len_eff = LEN_W'(1);
        end else if (pulse_len > LEN_W'(MAX_CYCLES)) begin
            len_eff = LEN_W'(MAX_CYCLES);
        end
    end

    // Mode 11 is folded onto re-arm before it is latched.
    assign mode_in = (mode == 2'b11) ? MODE_REARM : mode_e'(mode);

    always_comb begin
        trig_loop_defaults();
        for (int i = 0; i < NUM_CH; i++) begin
            logic sticky;
            logic last;
            logic complete;

            cnt_d[i]      = cnt_q[i];
            len_d[i]      = len_q[i];
            mode_d[i]     = mode_q[i];
            counting_d[i] = counting_q[i];

            // The sticky flag only exists for a pulse latched in one-shot mode.
            sticky = done_q[i] && (mode_q[i] == MODE_ONE_SHOT);
            last   = counting_q[i] && (cnt_q[i] == len_q[i] - LEN_W'(1));

            accept[i]  = trig[i] && !counting_q[i] && !sticky;
            restart[i] = trig[i] && counting_q[i] && (mode_q[i] == MODE_RETRIG);

            if (accept[i] || restart[i]) begin
                // Trigger cycle is the first high cycle; L-1 counting cycles follow.
                len_d[i]      = len_eff;
                counting_d[i] = (len_eff > LEN_W'(1));
                cnt_d[i]      = (len_eff > LEN_W'(1)) ? LEN_W'(1) : '0;
                if (accept[i]) begin
                    mode_d[i] = mode_in;
                end
            end else if (counting_q[i]) begin
                if (last) begin
                    counting_d[i] = 1'b0;
                    cnt_d[i]      = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + LEN_W'(1);
                end
            end

            // Completion lands on the cycle after the final high cycle.
            complete = (last && !restart[i]) ||
                       ((accept[i] || restart[i]) && (len_eff == LEN_W'(1)));

            // rearm can only act while sticky, i.e. never during a pulse;
            // a same-cycle en is already blocked by the sticky flag.
            done_d[i] = complete || (sticky && !rearm[i]);
        end
    end

    // Default values for the vector outputs of the loop above.
    function automatic void trig_loop_defaults();
        accept     = '0;
        restart    = '0;
        counting_d = '0;
        done_d     = '0;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            counting_q <= '0;
            done_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                len_q[i]  <= '0;
                mode_q[i] <= MODE_ONE_SHOT;
            end
        end else begin
            counting_q <= counting_d;
            done_q     <= done_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                len_q[i]  <= len_d[i];
                mode_q[i] <= mode_d[i];
            end
        end
    end

    // Gated by rstn so a held trigger cannot leak through during reset.
    assign out_pulse = (accept | counting_q) & {NUM_CH{rstn}};
    assign busy      = counting_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pulse_gen_v4.sv
module tb_pulse_gen_v4;
    localparam int NUM_CH     = 4;
    localparam int MAX_CYCLES = 256;
    localparam int LEN_W      = $clog2(MAX_CYCLES + 1);

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NUM_CH-1:0] en = '0;
    logic [1:0]        mode = '0;
    logic [LEN_W-1:0]  pulse_len = '0;
    logic [NUM_CH-1:0] rearm = '0;
    logic [NUM_CH-1:0] out_pulse;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    always #5 clk = ~clk;

    pulse_gen_v4 #(.NUM_CH(NUM_CH), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .pulse_len(pulse_len),
        .rearm(rearm), .out_pulse(out_pulse), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;
    int printed = 0;

    // Observed per-channel statistics for the literal checks
    int hi_cnt   [NUM_CH];
    int busy_cnt [NUM_CH];
    int done_cnt [NUM_CH];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // rem = high cycles still owed after the trigger cycle; done_m = done output.
    int          rem_m  [NUM_CH];
    int          mode_m [NUM_CH];
    logic [NUM_CH-1:0] done_m;
    logic [NUM_CH-1:0] en_prev;

    function automatic int eff_len(input int req);
        if (req == 0) return 1;
        if (req > MAX_CYCLES) return MAX_CYCLES;
        return req;
    endfunction

    task automatic cmp_vec(input string name, input logic [NUM_CH-1:0] got,
                           input logic [NUM_CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (printed < 40) begin
                printed++;
                $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
            end
        end
    endtask

    // The one compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        logic [NUM_CH-1:0] e_out, e_busy, e_done;
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rem_m[i] = 0;
                mode_m[i] = 0;
            end
            done_m  = '0;
            en_prev = '0;
            cmp_vec("reset_out", out_pulse, '0);
            cmp_vec("reset_busy", busy, '0);
            cmp_vec("reset_done", done, '0);
        end else begin
            int L;
            L = eff_len(int'(pulse_len));
            for (int i = 0; i < NUM_CH; i++) begin
                logic active, trg, sticky, acc, rst_p, fin;
                active = rem_m[i] > 0;
`ifdef PULSE_GEN_EDGE_TRIG_EN
                trg = en[i] & ~en_prev[i];
`else
                trg = en[i];
`endif
                sticky = done_m[i] && (mode_m[i] == 0);
                acc    = trg && !active && !sticky;
                rst_p  = trg && active && (mode_m[i] == 2);
                e_out[i]  = acc || active;
                e_busy[i] = active;
                e_done[i] = done_m[i];
                fin = (active && rem_m[i] == 1 && !rst_p) || ((acc || rst_p) && L == 1);
                if (acc) begin
                    mode_m[i] = (mode == 2'b11) ? 1 : int'(mode);
                    rem_m[i]  = L - 1;
                end else if (rst_p) begin
                    rem_m[i] = L - 1;
                end else if (active) begin
                    rem_m[i] = rem_m[i] - 1;
                end
                done_m[i] = fin || (sticky && !rearm[i]);
                if (out_pulse[i]) hi_cnt[i]++;
                if (busy[i]) busy_cnt[i]++;
                if (done[i]) done_cnt[i]++;
            end
            en_prev = en;
            cmp_vec("out_pulse", out_pulse, e_out);
            cmp_vec("busy", busy, e_busy);
            cmp_vec("done", done, e_done);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        for (int i = 0; i < NUM_CH; i++) begin
            hi_cnt[i] = 0;
            busy_cnt[i] = 0;
            done_cnt[i] = 0;
        end
    endtask

    task automatic fire(input logic [NUM_CH-1:0] m, input int len, input logic [1:0] md);
        mode = md;
        pulse_len = LEN_W'(len);
        en = m;
        cyc(1);
        en = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr_stats();
        cyc(3);
        chk("reset_out_lit", int'(out_pulse), 0);
        rstn = 1'b1;
        cyc(2);

        // One-shot, held en: single 32-cycle pulse, sticky done
        clr_stats();
        mode = 2'b00; pulse_len = 32; en = 4'b0001;
        cyc(100);
        en = '0;
        chk("os_hi", hi_cnt[0], 32);
        chk("os_busy", busy_cnt[0], 31);
        chk("os_done_sticky", int'(done[0]), 1);
        chk("os_done_len", done_cnt[0], 68);

        // rearm with en together: no pulse that cycle, then a fresh pulse
        clr_stats();
        rearm = 4'b0001; en = 4'b0001;
        cyc(1);
        rearm = '0; en = '0;
        chk("rearm_en_nopulse", hi_cnt[0], 0);
        fire(4'b0001, 32, 2'b00);
        cyc(40);
        chk("os_second_hi", hi_cnt[0], 32);
        rearm = 4'b0001; cyc(1); rearm = '0; cyc(1);

        // Retrigger: en at t0 and t0+5, len 8 -> 13 continuous, one done strobe
        clr_stats();
        fire(4'b0001, 8, 2'b10);
        cyc(4);
        fire(4'b0001, 8, 2'b10);
        cyc(20);
        chk("retrig_hi", hi_cnt[0], 13);
        chk("retrig_done", done_cnt[0], 1);

        // Re-arm: en at t0, t0+5, t0+8 -> two 8-cycle pulses
        clr_stats();
        fire(4'b0010, 8, 2'b01);
        cyc(4);
        fire(4'b0010, 8, 2'b01);
        cyc(2);
        fire(4'b0010, 8, 2'b01);
        cyc(20);
        chk("rearm_mode_hi", hi_cnt[1], 16);
        chk("rearm_mode_done", done_cnt[1], 2);

        // Boundary lengths
        clr_stats();
        fire(4'b1000, 0, 2'b01);
        cyc(5);
        chk("len0_hi", hi_cnt[3], 1);
        chk("len0_busy", busy_cnt[3], 0);
        clr_stats();
        fire(4'b1000, 300, 2'b11);
        cyc(2);
        pulse_len = 5;
        cyc(300);
        chk("len300_hi", hi_cnt[3], 256);

        // Two channels in flight, then asynchronous reset mid-pulse
        clr_stats();
        fire(4'b0100, 20, 2'b01);
        fire(4'b0001, 4, 2'b01);
        cyc(7);
        en = 4'b0100;
        rstn = 1'b0;
        #1;
        chk("mid_reset_out", int'(out_pulse), 0);
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_done", int'(done), 0);
        cyc(3);
        en = '0;
        rstn = 1'b1;
        cyc(1);
        clr_stats();
        fire(4'b0010, 6, 2'b00);
        cyc(10);
        chk("post_reset_hi", hi_cnt[1], 6);

        // Randomized traffic, compared every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                en[i]    = ($urandom_range(0, 99) < 15);
                rearm[i] = ($urandom_range(0, 99) < 10);
            end
            mode = 2'($urandom_range(0, 3));
            pulse_len = ($urandom_range(0, 19) == 0) ? LEN_W'(300)
                                                     : LEN_W'($urandom_range(0, 12));
            if ($urandom_range(0, 499) == 0) begin
                rstn = 1'b0;
                cyc(2);
                rstn = 1'b1;
            end
            cyc(1);
        end
        en = '0; rearm = '0;
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
